// File: rtl/int_req_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_req_pkg
// Description : Shared types and constants for the vectored-interrupt
//               requester (state encoding, register indices, source count).
// Revision    : 1.0 - initial release
// ============================================================================
package int_req_pkg;

  localparam int NSRC = 4;

  // Controller state, visible to software through STAT[1:0]
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Register word indices
  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_EOI  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  // One-hot encode a source index onto the done lines
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage : int_req_pkg
`default_nettype wire

// File: rtl/int_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : int_req_arb
// Description : Combinational selector picking one eligible interrupt source.
//               Fixed priority (source 0 highest) by default; rotating search
//               beginning at 'start' when INT_REQ_CTRL_ROUND_ROBIN_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module int_req_arb (
  input  logic [3:0] elig,
  input  logic [1:0] start,
  output logic [1:0] sel,
  output logic       valid
);

`ifdef INT_REQ_CTRL_ROUND_ROBIN_EN
  logic [1:0] idx;

  // Walk the four sources starting at 'start', wrapping modulo 4
  always_comb begin
    sel   = 2'd0;
    valid = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!valid && elig[idx]) begin
        sel   = idx;
        valid = 1'b1;
      end
    end
  end
`else
  // Start index has no meaning for fixed priority
  logic unused_start;
  assign unused_start = ^start;

  // Fixed priority, lowest index wins
  always_comb begin
    valid = |elig;
    if (elig[0])      sel = 2'd0;
    else if (elig[1]) sel = 2'd1;
    else if (elig[2]) sel = 2'd2;
    else              sel = 2'd3;
  end
`endif

endmodule : int_req_arb
`default_nettype wire

// File: rtl/int_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_req_ctrl
// Description : Device-side requester for the vectored-interrupt handshake.
//               Latches peripheral event pulses as pending bits, masks them,
//               raises one one-hot request on done[3:0] until int_ack, then
//               blocks further requests until software writes EOI.
//               Optional: INT_REQ_CTRL_ROUND_ROBIN_EN selects rotating
//               arbitration starting after the last acknowledged source.
// Revision    : 1.0 - initial release
// ============================================================================
module int_req_ctrl
  import int_req_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSRC   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        event_in,
  input  logic              int_ack,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [3:0]        done,
  output logic [1:0]        irq_id,
  output logic              busy
);

  // The done1..done4 interface is fixed at four lines
  if (NSRC != 4) begin : g_nsrc_check
    $error("int_req_ctrl: NSRC must be 4");
  end

  state_t     state, state_n;
  logic [3:0] mask, pending, ovf;
  logic [3:0] done_n;
  logic [1:0] irq_n;
  logic       busy_n;

  logic [3:0] elig;
  logic [1:0] arb_sel, arb_start;
  logic       arb_valid;

  logic       ack_take, eoi_wr, pend_wr;
  logic [3:0] pend_clr, ovf_clr, ovf_set;

  assign elig     = pending & mask;
  assign ack_take = (state == ST_REQ) && int_ack;
  assign eoi_wr   = we && (addr == REG_EOI) && (state == ST_SERVICE);
  assign pend_wr  = we && (addr == REG_PEND);

  // Clears come from the acknowledge and from PEND write-1-to-clear;
  // a same-cycle event on that bit overrides the clear.
  assign pend_clr = (ack_take ? onehot4(irq_id) : 4'b0000) |
                    (pend_wr ? wdata[3:0] : 4'b0000);
  assign ovf_clr  = pend_wr ? wdata[7:4] : 4'b0000;
  assign ovf_set  = event_in & pending & ~pend_clr;

`ifdef INT_REQ_CTRL_ROUND_ROBIN_EN
  logic [1:0] last_acked;

  // Remember the most recently acknowledged source for rotation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        last_acked <= 2'd3;
    else if (ack_take) last_acked <= irq_id;
  end

  assign arb_start = last_acked + 2'd1;
`else
  assign arb_start = 2'd0;
`endif

  int_req_arb u_arb (
    .elig  (elig),
    .start (arb_start),
    .sel   (arb_sel),
    .valid (arb_valid)
  );

  // Software-visible mask, pending and overflow bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask    <= 4'h0;
      pending <= 4'h0;
      ovf     <= 4'h0;
    end else begin
      if (we && (addr == REG_MASK)) mask <= wdata[3:0];
      pending <= (pending & ~pend_clr) | event_in;
      ovf     <= (ovf & ~ovf_clr) | ovf_set;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state decision; acknowledge takes precedence over revoke
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (arb_valid) state_n = ST_REQ;
      ST_REQ: begin
        if (int_ack)              state_n = ST_SERVICE;
        else if (!mask[irq_id])   state_n = ST_IDLE;
      end
      ST_SERVICE: if (eoi_wr) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Next values of the registered handshake outputs
  always_comb begin
    irq_n  = irq_id;
    done_n = 4'b0000;
    busy_n = (state_n != ST_IDLE);
    if (state == ST_IDLE && arb_valid) begin
      irq_n  = arb_sel;
      done_n = onehot4(arb_sel);
    end else if (state == ST_REQ && state_n == ST_REQ) begin
      done_n = done;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done   <= 4'b0000;
      irq_id <= 2'd0;
      busy   <= 1'b0;
    end else begin
      done   <= done_n;
      irq_id <= irq_n;
      busy   <= busy_n;
    end
  end

  // Register read mux; unused bits read as zero
  always_comb begin
    rdata = '0;
    case (addr)
      REG_MASK: rdata[3:0] = mask;
      REG_PEND: rdata[7:0] = {ovf, pending};
      REG_STAT: rdata[3:0] = {irq_id, state};
      default:  rdata      = '0;
    endcase
  end

endmodule : int_req_ctrl
`default_nettype wire

// File: tb/tb_int_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_req_ctrl
// Description : Directed self-checking bench for int_req_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_req_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  event_in;
  logic        int_ack;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  done;
  logic [1:0]  irq_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  int_req_ctrl #(.DATA_W(32), .NSRC(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .event_in (event_in),
    .int_ack  (int_ack),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .done     (done),
    .irq_id   (irq_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic pulse(input logic [3:0] ev);
    event_in = ev;
    tick();
    event_in = 4'b0000;
  endtask

  logic [31:0] r;

  initial begin
    reset = 1'b0; event_in = '0; int_ack = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_done", {28'd0, done}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_irq", {30'd0, irq_id}, 32'h0);
    rd(2'd0, r); check("rst_mask", r, 32'h0);
    rd(2'd3, r); check("rst_stat", r, 32'h0);
    reset = 1'b1;
    tick();

    // Single source 2
    wr(2'd0, 32'hF);
    rd(2'd0, r); check("mask_rb", r, 32'hF);
    pulse(4'b0100);
    check("lat1_done", {28'd0, done}, 32'h0);
    tick();
    check("s2_done", {28'd0, done}, 32'h4);
    check("s2_irq", {30'd0, irq_id}, 32'h2);
    check("s2_busy", {31'd0, busy}, 32'h1);
    rd(2'd3, r); check("s2_stat_req", r, 32'h9);
    wr(2'd2, 32'h0);  // EOI while in REQ: ignored
    rd(2'd3, r); check("eoi_in_req", r, 32'h9);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    check("s2_ack_done", {28'd0, done}, 32'h0);
    rd(2'd3, r); check("s2_stat_svc", r, 32'hA);
    rd(2'd1, r); check("s2_pend_clr", r, 32'h0);
    check("s2_busy_svc", {31'd0, busy}, 32'h1);
    wr(2'd2, 32'h0);
    rd(2'd3, r); check("s2_stat_idle", r, 32'h8);
    check("s2_busy_idle", {31'd0, busy}, 32'h0);

    // Two sources, priority order
    pulse(4'b1010);
    tick();
    check("p_first", {28'd0, done}, 32'h2);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    rd(2'd1, r); check("p_pend_svc", r, 32'h8);
    tick();
    check("p_blocked", {28'd0, done}, 32'h0);
    wr(2'd2, 32'h0);
    check("p_eoi_nodone", {28'd0, done}, 32'h0);
    tick();
    check("p_second", {28'd0, done}, 32'h8);
    check("p_second_irq", {30'd0, irq_id}, 32'h3);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    wr(2'd2, 32'h0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;  // ack in IDLE: ignored
    rd(2'd3, r); check("ack_idle", r, 32'hC);

    // Overflow and selective W1C
    event_in = 4'b0001; tick();
    event_in = 4'b0000; tick();
    check("o_done", {28'd0, done}, 32'h1);
    event_in = 4'b0001; tick(); event_in = 4'b0000;
    rd(2'd1, r); check("o_pend", r, 32'h11);
    wr(2'd1, 32'h10);
    rd(2'd1, r); check("o_w1c", r, 32'h01);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    wr(2'd2, 32'h0);
    rd(2'd1, r); check("o_pend_end", r, 32'h0);

    // Revoke by masking
    pulse(4'b1000);
    tick();
    check("r_done", {28'd0, done}, 32'h8);
    wr(2'd0, 32'h7);
    check("r_hold", {28'd0, done}, 32'h8);
    tick();
    check("r_revoked", {28'd0, done}, 32'h0);
    rd(2'd3, r); check("r_stat", r, 32'hC);
    rd(2'd1, r); check("r_pend", r, 32'h08);
    wr(2'd1, 32'h08);
    wr(2'd0, 32'hF);

    // Event on the acknowledged source in the ack cycle
    pulse(4'b0010);
    tick();
    check("c_done", {28'd0, done}, 32'h2);
    event_in = 4'b0010; int_ack = 1'b1; tick();
    event_in = 4'b0000; int_ack = 1'b0;
    rd(2'd1, r); check("c_pend", r, 32'h02);
    rd(2'd3, r); check("c_stat", r, 32'h6);
    wr(2'd2, 32'h0);
    tick();
    check("c_rereq", {28'd0, done}, 32'h2);

    // EOI reads as zero
    rd(2'd2, r); check("eoi_rd", r, 32'h0);

    // Asynchronous reset mid-REQ
    reset = 1'b0;
    #1;
    check("a_done", {28'd0, done}, 32'h0);
    check("a_busy", {31'd0, busy}, 32'h0);
    rd(2'd0, r); check("a_mask", r, 32'h0);
    rd(2'd1, r); check("a_pend", r, 32'h0);
    rd(2'd3, r); check("a_stat", r, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_int_req_ctrl
`default_nettype wire
